// File: rtl/irq_ctl.sv
// irq_ctl: edge-triggered interrupt controller beside the core.
// Rising edges on src latch into PENDING, MASK enables them, irq is held
// until the core takes the trap (pcsel==4). After that no further request
// is raised until software writes EOI.
// Optional build macro IRQ_SYNC_EN puts a 2-flop synchronizer in front of
// the edge detector, for asynchronous sources.
// Handshake: a take is a single cycle in REQ where irq (after the supervisor
// gate) is 1 and pcsel==3'd4. It is sampled on that clock edge. The core
// gives no ready/valid signal beyond this.
module irq_ctl #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] src,
  input  logic            supervisor,
  input  logic [2:0]      pcsel,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic            irq,
  output logic [IDW-1:0]  cause,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] src_prev_q, src_prev_d;
  logic [IDW-1:0]  cause_q, cause_d;
  logic            irq_q, irq_d;

  logic [NSRC-1:0] src_s;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] sel_onehot;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] take_clr;
  logic [IDW-1:0]  sel;
  logic            take;
  logic            eoi_wr;
  logic            unused_wdata;

  // Only the low NSRC bits of write data are meaningful.
  assign unused_wdata = ^cfg_wdata;

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  // Feed the two synchronizer stages.
  always_comb begin
    sync1_d = src;
    sync2_d = sync1_q;
  end

  // Synchronizer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  // Priority select: the lowest active index wins.
  always_comb begin
    sel        = '0;
    sel_onehot = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel        = IDW'(i);
        sel_onehot = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Edge detect, pending/mask update and request FSM next state.
  always_comb begin
    rise       = src_s & ~src_prev_q;
    active     = pending_q & mask_q;
    src_prev_d = src_s;
    w1c        = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[NSRC-1:0] : '0;
    eoi_wr     = cfg_we && cfg_addr == 2'd3;
    take       = (state_q == ST_REQ) && irq && (pcsel == 3'd4);
    take_clr   = take ? sel_onehot : '0;
    // A hardware set beats a software or take clear on the same bit.
    pending_d  = (pending_q & ~w1c & ~take_clr) | rise;
    mask_d     = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NSRC-1:0] : mask_q;
    state_d    = state_q;
    irq_d      = irq_q;
    cause_d    = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (active != '0) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (take) begin
          state_d = ST_SERVICE;
          cause_d = sel;
          irq_d   = 1'b0;
        end else if (active == '0) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      ST_SERVICE: begin
        irq_d = 1'b0;
        if (eoi_wr) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      mask_q     <= '0;
      src_prev_q <= '0;
      cause_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      src_prev_q <= src_prev_d;
      cause_q    <= cause_d;
      irq_q      <= irq_d;
    end
  end

  // Register read mux; unused bits read 0 and EOI reads 0.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata[NSRC-1:0] = pending_q;
      2'd1:    cfg_rdata[NSRC-1:0] = mask_q;
      2'd2:    cfg_rdata[IDW-1:0]  = cause_q;
      default: cfg_rdata = '0;
    endcase
  end

  assign irq       = irq_q & ~supervisor;
  assign cause     = cause_q;
  assign dbg_state = state_q;

endmodule
